// File: rtl/aes_gctr_ctrl.sv
// GCM counter-mode (GCTR) front end for aes_core_top.
// Builds counter blocks from J0 using inc32, sends one block at a time to the AES core,
// XORs the returned keystream with plaintext and presents the ciphertext to GHASH/output.
// Optional build macro GCTR_EKJ0_EN: computes E(K,J0) up front and presents it as the
// tag mask; when undefined the tag outputs are tied to zero.
//
// state | meaning
// IDLE  | waiting for i_start
// EKJ0  | (GCTR_EKJ0_EN) issue J0, wait for E(K,J0), pulse o_tag_valid
// GETPT | accepting the next plaintext block
// ISSUE | presenting the counter block, waiting for core ready
// WAIT  | waiting for the keystream from the core
// OUT   | holding ciphertext until downstream accepts it
module aes_gctr_ctrl #(
    parameter int RND_SIZE = 128,
    parameter int CTR_SIZE = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [RND_SIZE-1:0] i_j0,
    input  logic [RND_SIZE-1:0] i_key,
    input  logic                i_pt_valid,
    output logic                o_pt_ready,
    input  logic [RND_SIZE-1:0] i_pt_data,
    input  logic                i_pt_last,
    input  logic [4:0]          i_pt_nbytes,
    output logic                o_ct_valid,
    input  logic                i_ct_ready,
    output logic [RND_SIZE-1:0] o_ct_data,
    output logic                o_ct_last,
    output logic                o_core_en,
    output logic [RND_SIZE-1:0] o_core_msg,
    output logic [RND_SIZE-1:0] o_core_key,
    input  logic                i_core_ready,
    input  logic                i_core_valid,
    input  logic [RND_SIZE-1:0] i_core_cypher,
    output logic                o_busy,
    output logic [RND_SIZE-1:0] o_tag_mask,
    output logic                o_tag_valid
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EKJ0  = 3'd1,
        S_GETPT = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t              state, state_nxt;
    logic [RND_SIZE-1:0] ctr;
    logic [RND_SIZE-1:0] key_reg;
    logic [RND_SIZE-1:0] pt_reg;
    logic [RND_SIZE-1:0] ct_reg;
    logic                last_reg;
    logic [4:0]          nbytes_reg;

    // Keep bytes 0..n-1 (byte 0 in the MSBs); n = 0 means a full block.
    function automatic logic [127:0] byte_mask(input logic [4:0] nb);
        logic [127:0] m;
        int           n_eff;
        m     = '0;
        n_eff = (nb == 5'd0) ? 16 : int'(nb);
        for (int k = 0; k < 16; k++) begin
            m[127-8*k -: 8] = (k < n_eff) ? 8'hFF : 8'h00;
        end
        return m;
    endfunction

`ifdef GCTR_EKJ0_EN
    // 0: issue J0, 1: wait for E(K,J0), 2: tag pulse cycle
    logic [1:0]          ekj0_step;
    logic [RND_SIZE-1:0] tag_mask_reg;
    logic                tag_valid_reg;

    // E(K,J0) sub-sequence and tag mask register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ekj0_step     <= 2'd0;
            tag_mask_reg  <= '0;
            tag_valid_reg <= 1'b0;
        end else begin
            tag_valid_reg <= 1'b0;
            if (state == S_EKJ0) begin
                case (ekj0_step)
                    2'd0: if (i_core_ready) ekj0_step <= 2'd1;
                    2'd1: if (i_core_valid) begin
                        tag_mask_reg  <= i_core_cypher;
                        tag_valid_reg <= 1'b1;
                        ekj0_step     <= 2'd2;
                    end
                    default: ekj0_step <= 2'd0;
                endcase
            end else begin
                ekj0_step <= 2'd0;
            end
        end
    end

    assign o_tag_mask  = tag_mask_reg;
    assign o_tag_valid = tag_valid_reg;
`else
    assign o_tag_mask  = '0;
    assign o_tag_valid = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt  = state;
        o_pt_ready = 1'b0;
        o_core_en  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
`ifdef GCTR_EKJ0_EN
                    state_nxt = S_EKJ0;
`else
                    state_nxt = S_GETPT;
`endif
                end
            end
`ifdef GCTR_EKJ0_EN
            S_EKJ0: begin
                o_core_en = (ekj0_step == 2'd0) && i_core_ready;
                if (ekj0_step == 2'd2) state_nxt = S_GETPT;
            end
`endif
            S_GETPT: begin
                o_pt_ready = 1'b1;
                if (i_pt_valid) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                o_core_en = i_core_ready;
                if (i_core_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_core_valid) state_nxt = S_OUT;
            end
            S_OUT: begin
                if (i_ct_ready) state_nxt = last_reg ? S_IDLE : S_GETPT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counter, key, plaintext and ciphertext registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr        <= '0;
            key_reg    <= '0;
            pt_reg     <= '0;
            ct_reg     <= '0;
            last_reg   <= 1'b0;
            nbytes_reg <= 5'd0;
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    ctr     <= i_j0;
                    key_reg <= i_key;
                end
                S_GETPT: if (i_pt_valid) begin
                    pt_reg     <= i_pt_data;
                    last_reg   <= i_pt_last;
                    nbytes_reg <= i_pt_nbytes;
                    ctr        <= {ctr[RND_SIZE-1:CTR_SIZE], ctr[CTR_SIZE-1:0] + CTR_SIZE'(1)};
                end
                S_WAIT: if (i_core_valid) begin
                    ct_reg <= (pt_reg ^ i_core_cypher) &
                              (last_reg ? byte_mask(nbytes_reg) : {RND_SIZE{1'b1}});
                end
                default: ;
            endcase
        end
    end

    assign o_core_msg = ctr;
    assign o_core_key = key_reg;
    assign o_ct_data  = ct_reg;
    assign o_ct_valid = (state == S_OUT);
    assign o_ct_last  = (state == S_OUT) && last_reg;
    assign o_busy     = (state != S_IDLE);

endmodule

// File: tb/tb_aes_gctr_ctrl.sv
// Directed bench for aes_gctr_ctrl with a small behavioural AES core stand-in.
// The stand-in returns the true AES-128 outputs for the NIST GCM TC2 counter blocks
// and an easily recomputed pseudo-keystream for everything else.
module tb_aes_gctr_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_start = 1'b0;
    logic [127:0] i_j0 = '0;
    logic [127:0] i_key = '0;
    logic         i_pt_valid = 1'b0;
    logic         o_pt_ready;
    logic [127:0] i_pt_data = '0;
    logic         i_pt_last = 1'b0;
    logic [4:0]   i_pt_nbytes = 5'd0;
    logic         o_ct_valid;
    logic         i_ct_ready = 1'b0;
    logic [127:0] o_ct_data;
    logic         o_ct_last;
    logic         o_core_en;
    logic [127:0] o_core_msg;
    logic [127:0] o_core_key;
    logic         i_core_ready = 1'b1;
    logic         i_core_valid = 1'b0;
    logic [127:0] i_core_cypher = '0;
    logic         o_busy;
    logic [127:0] o_tag_mask;
    logic         o_tag_valid;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] KS_TC2_J0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] KS_TC2_C1 = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam int           CORE_LAT  = 4;

    aes_gctr_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_j0          (i_j0),
        .i_key         (i_key),
        .i_pt_valid    (i_pt_valid),
        .o_pt_ready    (o_pt_ready),
        .i_pt_data     (i_pt_data),
        .i_pt_last     (i_pt_last),
        .i_pt_nbytes   (i_pt_nbytes),
        .o_ct_valid    (o_ct_valid),
        .i_ct_ready    (i_ct_ready),
        .o_ct_data     (o_ct_data),
        .o_ct_last     (o_ct_last),
        .o_core_en     (o_core_en),
        .o_core_msg    (o_core_msg),
        .o_core_key    (o_core_key),
        .i_core_ready  (i_core_ready),
        .i_core_valid  (i_core_valid),
        .i_core_cypher (i_core_cypher),
        .o_busy        (o_busy),
        .o_tag_mask    (o_tag_mask),
        .o_tag_valid   (o_tag_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] ks_of(input logic [127:0] k, input logic [127:0] m);
        if (k == '0 && m == 128'h1) return KS_TC2_J0;
        if (k == '0 && m == 128'h2) return KS_TC2_C1;
        return {m[63:0], m[127:64]} ^ k ^ 128'h5a5a_5a5a_0f0f_0f0f_3c3c_3c3c_a5a5_a5a5;
    endfunction

    // Core stand-in: request seen at a posedge, answer CORE_LAT negedges later.
    logic         en_q;
    logic [127:0] msg_q, key_q, pend_ks, last_msg;
    int           core_cnt = 0;
    int           en_total = 0;

    always @(posedge clk) begin
        en_q  <= o_core_en;
        msg_q <= o_core_msg;
        key_q <= o_core_key;
    end

    always @(negedge clk) begin
        i_core_valid = 1'b0;
        if (en_q === 1'b1) begin
            en_total++;
            last_msg     = msg_q;
            pend_ks      = ks_of(key_q, msg_q);
            core_cnt     = CORE_LAT;
            i_core_ready = 1'b0;
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                i_core_valid  = 1'b1;
                i_core_cypher = pend_ks;
                i_core_ready  = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pt_ready"}, o_pt_ready, 0);
        check({tag, "_ct_valid"}, o_ct_valid, 0);
        check({tag, "_ct_data"},  o_ct_data,  0);
        check({tag, "_ct_last"},  o_ct_last,  0);
        check({tag, "_core_en"},  o_core_en,  0);
        check({tag, "_core_msg"}, o_core_msg, 0);
        check({tag, "_core_key"}, o_core_key, 0);
        check({tag, "_busy"},     o_busy,     0);
        check({tag, "_tag_mask"}, o_tag_mask, 0);
        check({tag, "_tag_vld"},  o_tag_valid, 0);
    endtask

    // All tasks are entered and left on a falling edge.
    task automatic start_msg(input logic [127:0] j0, input logic [127:0] key);
        i_start = 1'b1;
        i_j0    = j0;
        i_key   = key;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic put_pt(input logic [127:0] d, input logic last, input logic [4:0] nb);
        int n = 0;
        i_pt_valid  = 1'b1;
        i_pt_data   = d;
        i_pt_last   = last;
        i_pt_nbytes = nb;
        while (o_pt_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pt_ready_wait", n < 200, 1);
        @(negedge clk);
        i_pt_valid = 1'b0;
    endtask

    task automatic wait_ct(input string tag);
        int n = 0;
        while (o_ct_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ct_wait"}, n < 200, 1);
    endtask

    task automatic get_ct(input string tag, input logic [127:0] exp_d, input logic exp_last);
        wait_ct(tag);
        check({tag, "_data"}, o_ct_data, exp_d);
        check({tag, "_last"}, o_ct_last, exp_last);
        i_ct_ready = 1'b1;
        @(negedge clk);
        i_ct_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] p, exp_ct, j0;
        int           en_before;

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // T1 / T2: NIST GCM TC2
        start_msg(128'h1, '0);
        check("t1_busy", o_busy, 1);
`ifdef GCTR_EKJ0_EN
        begin
            int n = 0;
            logic early_ready = 1'b0;
            while (o_tag_valid !== 1'b1 && n < 200) begin
                if (o_pt_ready === 1'b1) early_ready = 1'b1;
                @(negedge clk);
                n++;
            end
            check("t2_tag_wait", n < 200, 1);
            check("t2_ready_before_tag", early_ready, 0);
            check("t2_ready_at_tag", o_pt_ready, 0);
            check("t2_tag_mask", o_tag_mask, KS_TC2_J0);
            check("t2_j0_issued", last_msg, 128'h1);
            @(negedge clk);
            check("t2_tag_pulse", o_tag_valid, 0);
            check("t2_tag_hold", o_tag_mask, KS_TC2_J0);
        end
`endif
        put_pt('0, 1'b1, 5'd16);
        get_ct("t1", 128'h0388dace60b6a392f328c2b971b2fe78, 1'b1);
        check("t1_ctr", last_msg, 128'h2);
        check("t1_busy_done", o_busy, 0);

        // T3: inc32 wraps, upper 96 bits untouched; nbytes ignored when not last
        start_msg(128'hCAFEBABE_DEADBEEF_01234567_FFFFFFFF, 128'h000102030405060708090a0b0c0d0e0f);
        p = 128'h11112222_33334444_55556666_77778888;
        put_pt(p, 1'b0, 5'd3);
        exp_ct = p ^ ks_of(128'h000102030405060708090a0b0c0d0e0f, 128'hCAFEBABE_DEADBEEF_01234567_00000000);
        get_ct("t3b0", exp_ct, 1'b0);
        check("t3b0_msg", last_msg, 128'hCAFEBABE_DEADBEEF_01234567_00000000);
        p = 128'h0badf00d_12345678_9abcdef0_fedcba98;
        put_pt(p, 1'b1, 5'd0);
        exp_ct = p ^ ks_of(128'h000102030405060708090a0b0c0d0e0f, 128'hCAFEBABE_DEADBEEF_01234567_00000001);
        get_ct("t3b1", exp_ct, 1'b1);
        check("t3b1_msg", last_msg, 128'hCAFEBABE_DEADBEEF_01234567_00000001);

        // T4: last block with 5 valid bytes
        start_msg(128'h01020304_05060708_090a0b0c_00000010, 128'hffeeddcc_bbaa9988_77665544_33221100);
        p = 128'hdeadbeef_cafef00d_55aa55aa_12345678;
        put_pt(p, 1'b1, 5'd5);
        exp_ct = (p ^ ks_of(128'hffeeddcc_bbaa9988_77665544_33221100, 128'h01020304_05060708_090a0b0c_00000011))
                 & 128'hffffffff_ff000000_00000000_00000000;
        get_ct("t4", exp_ct, 1'b1);

        // T5: back-pressure holds output steady; i_start mid-message ignored
        j0 = 128'h10000000_20000000_30000000_7ffffffe;
        start_msg(j0, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
        p = 128'ha5a5a5a5_00000000_ffffffff_5a5a5a5a;
        put_pt(p, 1'b0, 5'd16);
        exp_ct = p ^ ks_of(128'h0f0e0d0c_0b0a0908_07060504_03020100, 128'h10000000_20000000_30000000_7fffffff);
        wait_ct("t5_hold");
        en_before = en_total;
        for (int c = 0; c < 10; c++) begin
            check("t5_hold_valid", o_ct_valid, 1);
            check("t5_hold_data", o_ct_data, exp_ct);
            check("t5_hold_ready", o_pt_ready, 0);
            i_start = (c == 3);
            i_j0    = 128'h99999999_99999999_99999999_99999999;
            i_key   = 128'h77777777_77777777_77777777_77777777;
            @(negedge clk);
        end
        i_start = 1'b0;
        check("t5_no_core_en", en_total, en_before);
        get_ct("t5b0", exp_ct, 1'b0);
        p = 128'h01010101_02020202_03030303_04040404;
        put_pt(p, 1'b1, 5'd16);
        exp_ct = p ^ ks_of(128'h0f0e0d0c_0b0a0908_07060504_03020100, 128'h10000000_20000000_30000000_80000000);
        get_ct("t5b1", exp_ct, 1'b1);
        check("t5b1_msg", last_msg, 128'h10000000_20000000_30000000_80000000);

        // T6: reset during WAIT, then a fresh TC2 message
        start_msg(128'h44444444_44444444_44444444_00000005, 128'h13579bdf_2468ace0_13579bdf_2468ace0);
        put_pt(128'hffffffff_ffffffff_ffffffff_ffffffff, 1'b1, 5'd16);
        @(negedge clk);
        check("t6_in_wait", o_busy, 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_msg(128'h1, '0);
        put_pt('0, 1'b1, 5'd16);
        get_ct("t6", 128'h0388dace60b6a392f328c2b971b2fe78, 1'b1);
        check("t6_busy_done", o_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
